// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared definitions for the SPART serial port: bus register
//                addresses, oversampling constants and the TX/RX state
//                encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package spart_pkg;

    // Bus register map (ioaddr)
    localparam logic [1:0] ADDR_BUF  = 2'b00;   // TX buffer (write) / RX buffer (read)
    localparam logic [1:0] ADDR_STAT = 2'b01;   // status {5'b0, ferr, tbr, rda}
    localparam logic [1:0] ADDR_DBL  = 2'b10;   // divisor low byte
    localparam logic [1:0] ADDR_DBH  = 2'b11;   // divisor high byte

    // Baud ticks per serial bit, and ticks from a start edge to mid start bit
    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;

    // Terminal values of the 4-bit per-bit tick counters
    localparam logic [3:0] c_tick_last = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_half_last = 4'(HALF_BIT - 1);

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spart_baud_gen
//  Description : 16-bit down counter producing a one-cycle tick every
//                divisor+1 clocks (16x the serial bit rate). A divisor of 0
//                ticks on every clock.
//  Ports       : clk, rst (async, active-low)
//                i_divisor  - reload value
//                i_load     - restart the count from i_divisor
//                o_tick     - oversampling tick
//  Revision    : 1.0  initial release
// ============================================================================
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd324
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_divisor,
    input  logic        i_load,
    output logic        o_tick
);

    logic [15:0] r_cnt;

    // The tick is the cycle in which the count sits at zero; the same edge
    // that consumes the tick reloads the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= DEFAULT_DIV;
        end else if (i_load || (r_cnt == 16'd0)) begin
            r_cnt <= i_divisor;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    assign o_tick = (r_cnt == 16'd0);

endmodule
`default_nettype wire

// File: rtl/spart.sv
`default_nettype none
// ============================================================================
//  Module      : spart
//  Description : Special-purpose UART. Decodes the 8-bit processor bus into
//                TX/RX buffer, status and baud divisor registers, and
//                serialises/deserialises 8N1 frames with 16x oversampling.
//  Ports       : clk, rst (async, active-low)
//                iocs, iorw, ioaddr[1:0], databus[7:0] (inout) - processor bus
//                rda  - receive data available
//                tbr  - transmit buffer ready (transmitter idle)
//                txd  - serial out (idle high), rxd - serial in (async)
//  Options     : SPART_FERR_EN - sticky framing-error flag in status[2],
//                cleared by a status read.
//  Revision    : 1.0  initial release
// ============================================================================
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd324
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_wr;
    logic       w_rd;
    logic       w_rd_buf;
    logic       w_ferr;
    logic [7:0] w_rdata;
    logic [7:0] r_rx_buf;

    assign w_wr     = iocs & ~iorw;
    assign w_rd     = iocs &  iorw;
    assign w_rd_buf = w_rd & (ioaddr == ADDR_BUF);

    always_comb begin
        w_rdata = r_rx_buf;
        if (ioaddr == ADDR_STAT) begin
            w_rdata = {5'b0, w_ferr, tbr, rda};
        end
    end

    // Only the buffer and status addresses are readable; divisor reads float.
    assign databus = (w_rd && !ioaddr[1]) ? w_rdata : 8'hzz;

    // ------------------------------------------------------------------
    // Divisor register and baud generator
    // ------------------------------------------------------------------
    logic [15:0] r_div;
    logic [15:0] w_div_next;
    logic        w_div_load;
    logic        w_tick;

    always_comb begin
        w_div_next = r_div;
        w_div_load = 1'b0;
        if (w_wr && (ioaddr == ADDR_DBL)) begin
            w_div_next[7:0] = databus;
            w_div_load      = 1'b1;
        end else if (w_wr && (ioaddr == ADDR_DBH)) begin
            w_div_next[15:8] = databus;
            w_div_load       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= DEFAULT_DIV;
        end else begin
            r_div <= w_div_next;
        end
    end

    // The generator reloads from the post-write value so a divisor write
    // restarts the count with the new setting on the same edge.
    spart_baud_gen #(
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .i_divisor (w_div_next),
        .i_load    (w_div_load),
        .o_tick    (w_tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t  r_tx_state;
    logic [9:0] r_tx_shift;
    logic [3:0] r_tx_tcnt;
    logic [3:0] r_tx_bcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '1;
            r_tx_tcnt  <= 4'd0;
            r_tx_bcnt  <= 4'd0;
            tbr        <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_wr && (ioaddr == ADDR_BUF)) begin
                        r_tx_shift <= {1'b1, databus, 1'b0};
                        r_tx_tcnt  <= 4'd0;
                        r_tx_bcnt  <= 4'd0;
                        tbr        <= 1'b0;
                        r_tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == c_tick_last) begin
                            r_tx_tcnt  <= 4'd0;
                            // Shift in ones so the line idles high once the
                            // stop bit has gone out.
                            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                            if (r_tx_bcnt == 4'd9) begin
                                tbr        <= 1'b1;
                                r_tx_state <= TX_IDLE;
                            end else begin
                                r_tx_bcnt <= r_tx_bcnt + 4'd1;
                            end
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign txd = r_tx_shift[0];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t  r_rx_state;
    logic       r_rx_s1;
    logic       r_rx_s2;
    logic       r_rx_prev;
    logic [3:0] r_rx_tcnt;
    logic [2:0] r_rx_bcnt;
    logic [7:0] r_rx_shift;
    logic       w_rx_fall;
    logic       w_stop_sample;
    logic       w_frame_good;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
    assign w_stop_sample = (r_rx_state == RX_STOP) && w_tick && (r_rx_tcnt == c_tick_last);
    assign w_frame_good  = w_stop_sample & r_rx_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_tcnt  <= 4'd0;
            r_rx_bcnt  <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_buf   <= 8'd0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_tcnt  <= 4'd0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == c_half_last) begin
                            r_rx_tcnt <= 4'd0;
                            r_rx_bcnt <= 3'd0;
                            // A line already back high mid start bit is a glitch.
                            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == c_tick_last) begin
                            r_rx_tcnt  <= 4'd0;
                            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                            if (r_rx_bcnt == 3'd7) begin
                                r_rx_state <= RX_STOP;
                            end else begin
                                r_rx_bcnt <= r_rx_bcnt + 3'd1;
                            end
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == c_tick_last) begin
                            r_rx_tcnt  <= 4'd0;
                            r_rx_state <= RX_IDLE;
                            if (r_rx_s2) begin
                                r_rx_buf <= r_rx_shift;
                            end
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // A new byte beats a simultaneous buffer read, so rda stays set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rda <= 1'b0;
        end else if (w_frame_good) begin
            rda <= 1'b1;
        end else if (w_rd_buf) begin
            rda <= 1'b0;
        end
    end

`ifdef SPART_FERR_EN
    logic w_rd_stat;
    logic w_frame_bad;
    logic r_ferr;

    assign w_rd_stat   = w_rd & (ioaddr == ADDR_STAT);
    assign w_frame_bad = w_stop_sample & ~r_rx_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ferr <= 1'b0;
        end else if (w_frame_bad) begin
            r_ferr <= 1'b1;
        end else if (w_rd_stat) begin
            r_ferr <= 1'b0;
        end
    end

    assign w_ferr = r_ferr;
`else
    assign w_ferr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart
//  Description : Directed self-checking bench for spart. The bench keeps a
//                weak-looking probe value (0x81) on databus whenever it is not
//                reading, so a floating spart shows exactly 0x81 and any
//                spart drive corrupts it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spart;
    import spart_pkg::*;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       iocs   = 1'b0;
    logic       iorw   = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic       rxd    = 1'b1;
    logic [7:0] tb_data = 8'h81;
    logic       tb_oe   = 1'b1;
    wire  [7:0] databus;
    wire        rda;
    wire        tbr;
    wire        txd;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [7:0] c_probe = 8'h81;

    assign databus = tb_oe ? tb_data : 8'hzz;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = addr;
        tb_data = data;
        step();
        iocs    = 1'b0;
        tb_data = c_probe;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = addr;
        tb_oe  = 1'b0;
        #1;
        data = databus;
        step();
        iocs  = 1'b0;
        iorw  = 1'b0;
        tb_oe = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (64) step();
        end
        rxd = 1'b1;
    endtask

    initial begin
        logic [7:0] rd;
        logic [9:0] frame;

        // ---------------- reset values ----------------
        repeat (3) step();
        check("rst_txd", {7'd0, txd}, 8'd1);
        check("rst_tbr", {7'd0, tbr}, 8'd1);
        check("rst_rda", {7'd0, rda}, 8'd0);
        check("rst_bus_z", databus, c_probe);
        rst = 1'b1;

        // ---------------- default divisor 324 via TX timing ----------------
        // Ticks land on edges N+324+325k; the 16th ends the start bit at c=5199.
        bus_write(ADDR_BUF, 8'hFF);
        check("dflt_tbr_low", {7'd0, tbr}, 8'd0);
        repeat (5190) step();
        check("dflt_start_c5190", {7'd0, txd}, 8'd0);
        repeat (20) step();
        check("dflt_bit0_c5210", {7'd0, txd}, 8'd1);

        // ---------------- mid-frame reset ----------------
        rst = 1'b0;
        #1;
        check("midrst_tbr", {7'd0, tbr}, 8'd1);
        check("midrst_txd", {7'd0, txd}, 8'd1);
        repeat (2) step();
        rst = 1'b1;
        step();

        bus_read(ADDR_STAT, rd);
        check("stat_idle", rd, 8'h02);

        // ---------------- TX 0xA5 at divisor 3 ----------------
        bus_write(ADDR_DBL, 8'h03);
        bus_write(ADDR_DBH, 8'h00);
        bus_write(ADDR_BUF, 8'hA5);
        check("tx_tbr_low", {7'd0, tbr}, 8'd0);
        check("tx_start_c0", {7'd0, txd}, 8'd0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int c = 0; c < 640; c++) begin
            if ((c % 64) == 30) begin
                check($sformatf("tx_bit%0d", c / 64), {7'd0, txd}, {7'd0, frame[c / 64]});
            end
            if (c == 638) check("tx_tbr_c638", {7'd0, tbr}, 8'd0);
            if (c == 639) check("tx_tbr_c639", {7'd0, tbr}, 8'd1);
            if (c == 100) begin
                // Write while busy must not disturb the frame.
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = ADDR_BUF;
                tb_data = 8'hFF;
            end else if (c == 101) begin
                iocs    = 1'b0;
                tb_data = c_probe;
            end
            step();
        end
        check("tx_idle_txd", {7'd0, txd}, 8'd1);

        // ---------------- RX 0x3C ----------------
        send_frame(8'h3C, 1'b1);
        check("rx_rda_set", {7'd0, rda}, 8'd1);
        bus_read(ADDR_BUF, rd);
        check("rx_data_3c", rd, 8'h3C);
        check("rx_rda_clr", {7'd0, rda}, 8'd0);

        // ---------------- bus float checks ----------------
        iorw   = 1'b1;
        ioaddr = ADDR_BUF;
        #1;
        check("bus_z_nocs", databus, c_probe);
        iocs   = 1'b1;
        ioaddr = ADDR_DBL;
        #1;
        check("bus_z_div", databus, c_probe);
        iocs = 1'b0;
        iorw = 1'b0;
        step();

        // ---------------- false start ----------------
        rxd = 1'b0;
        repeat (20) step();
        rxd = 1'b1;
        repeat (100) step();
        check("fs_rda", {7'd0, rda}, 8'd0);
        send_frame(8'h96, 1'b1);
        check("fs_next_rda", {7'd0, rda}, 8'd1);
        bus_read(ADDR_BUF, rd);
        check("fs_next_data", rd, 8'h96);

        // ---------------- framing error ----------------
        send_frame(8'h55, 1'b0);
        repeat (20) step();
        check("ferr_rda", {7'd0, rda}, 8'd0);
        bus_read(ADDR_STAT, rd);
`ifdef SPART_FERR_EN
        check("ferr_stat1", rd, 8'h06);
`else
        check("ferr_stat1", rd, 8'h02);
`endif
        bus_read(ADDR_STAT, rd);
        check("ferr_stat2", rd, 8'h02);
        bus_read(ADDR_BUF, rd);
        check("ferr_buf_kept", rd, 8'h96);

        // ---------------- overrun ----------------
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_rda", {7'd0, rda}, 8'd1);
        bus_read(ADDR_BUF, rd);
        check("ovr_data", rd, 8'h22);
        check("ovr_rda_clr", {7'd0, rda}, 8'd0);

        // ---------------- reset with everything busy ----------------
        send_frame(8'h77, 1'b1);
        check("busy_rda", {7'd0, rda}, 8'd1);
        bus_write(ADDR_BUF, 8'h00);
        rxd = 1'b0;
        repeat (50) step();
        rst = 1'b0;
        #1;
        check("rst2_rda", {7'd0, rda}, 8'd0);
        check("rst2_tbr", {7'd0, tbr}, 8'd1);
        check("rst2_txd", {7'd0, txd}, 8'd1);
        check("rst2_bus_z", databus, c_probe);
        rxd = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        repeat (700) step();
        check("rst2_after_rda", {7'd0, rda}, 8'd0);
        check("rst2_after_txd", {7'd0, txd}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
